// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 message words, then streams W[0..63]
// through a 16-deep shift register with the FIPS 180-4 expansion.
module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] W,
    output logic [5:0]  round,
    output logic        w_first,
    output logic        w_last
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ROUND_W = 6;

    typedef enum logic {ST_LOAD, ST_EMIT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    load_cnt;
    logic [ROUND_W-1:0]  round_cnt;
    logic [WORD_W-1:0]   r [DEPTH];
    logic [WORD_W-1:0]   w_new;
    logic                in_xfer;
    logic                out_xfer;
    logic                load_done;
    logic                emit_done;

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Handshake flags are decoded from the state register only
    assign in_ready  = (state == ST_LOAD);
    assign w_valid   = (state == ST_EMIT);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = w_valid && w_ready;
    assign load_done = in_xfer && (load_cnt == CNT_W'(DEPTH - 1));
    assign emit_done = out_xfer && (round_cnt == ROUND_W'(63));

    assign W       = r[0];
    assign round   = round_cnt;
    assign w_first = w_valid && (round_cnt == ROUND_W'(0));
    assign w_last  = w_valid && (round_cnt == ROUND_W'(63));

    // r[0..15] holds W[t..t+15]; the next word is W[t+16]
    assign w_new = sig1(r[14]) + r[9] + sig0(r[1]) + r[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (load_done) state_nxt = ST_EMIT;
            ST_EMIT: if (emit_done) state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            round_cnt <= '0;
        end else begin
            if (in_xfer) begin
                load_cnt <= load_cnt + CNT_W'(1);
            end
            if (load_done) begin
                round_cnt <= '0;
            end else if (out_xfer) begin
                round_cnt <= round_cnt + ROUND_W'(1);
            end
        end
    end

    // Schedule storage is intentionally not reset; a new block overwrites it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_xfer) begin
                r[load_cnt] <= in_word;
            end else if (out_xfer) begin
                for (int i = 0; i < 15; i++) begin
                    r[i] <= r[i+1];
                end
                r[15] <= w_new;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed self-checking bench for sha256_msg_sched against a FIPS 180-4 model.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] W;
    logic [5:0]  round;
    logic        w_first;
    logic        w_last;

    int errors = 0;
    int checks = 0;

    logic [31:0] msg_a [16];
    logic [31:0] msg_b [16];
    logic [31:0] exp_a [64];
    logic [31:0] exp_b [64];
    logic [31:0] cap   [64];

    always #5 clk = ~clk;

    sha256_msg_sched dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .W        (W),
        .round    (round),
        .w_first  (w_first),
        .w_last   (w_last)
    );

    function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model(input bit sel_b);
        logic [31:0] e [64];
        logic [31:0] a, b;
        for (int t = 0; t < 16; t++) e[t] = sel_b ? msg_b[t] : msg_a[t];
        for (int t = 16; t < 64; t++) begin
            a = ref_rotr(e[t-15], 7) ^ ref_rotr(e[t-15], 18) ^ (e[t-15] >> 3);
            b = ref_rotr(e[t-2], 17) ^ ref_rotr(e[t-2], 19) ^ (e[t-2] >> 10);
            e[t] = b + e[t-7] + a + e[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            if (sel_b) exp_b[t] = e[t];
            else       exp_a[t] = e[t];
        end
    endtask

    task automatic do_reset(input bit busy);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = busy;
        w_ready  = busy;
        in_word  = $urandom;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || w_valid !== 1'b0 || w_first !== 1'b0 ||
            w_last !== 1'b0 || round !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b w_valid=%b w_first=%b w_last=%b round=%0d, required 1 0 0 0 0",
                     in_ready, w_valid, w_first, w_last, round);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        w_ready  = 1'b0;
    endtask

    task automatic send_block(input bit sel_b, input bit gaps, input int nwords);
        int  cnt = 0;
        int  cyc = 0;
        bit  ir;
        w_ready = 1'b0;
        while (cnt < nwords && cyc < 400) begin
            @(negedge clk);
            ir = in_ready;
            if (cnt > 0 || cyc > 0) begin
                checks++;
                if (ir !== 1'b1 || w_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL load_flags: in_ready=%b w_valid=%b, required 1 0", ir, w_valid);
                end
            end
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_word  = in_valid ? (sel_b ? msg_b[cnt] : msg_a[cnt]) : $urandom;
            @(posedge clk);
            if (in_valid && ir) cnt++;
            cyc++;
        end
        if (cnt < nwords) begin
            errors++;
            $display("FAIL load_timeout: words=%0d, required %0d", cnt, nwords);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (nwords == 16) begin
            checks++;
            if (w_valid !== 1'b1 || in_ready !== 1'b0 || round !== 6'd0 || w_first !== 1'b1) begin
                errors++;
                $display("FAIL emit_start: w_valid=%b in_ready=%b round=%0d w_first=%b, required 1 0 0 1",
                         w_valid, in_ready, round, w_first);
            end
        end
    endtask

    task automatic recv_block(input bit sel_b, input bit stalls, input bit noise, input int stop_at);
        int t   = 0;
        int cyc = 0;
        bit wv;
        logic [31:0] e;
        while (t < stop_at && cyc < 1000) begin
            @(negedge clk);
            wv = w_valid;
            e  = sel_b ? exp_b[t] : exp_a[t];
            checks++;
            if (wv !== 1'b1 || W !== e || round !== 6'(t) ||
                w_first !== (t == 0) || w_last !== (t == 63)) begin
                errors++;
                $display("FAIL emit_word t=%0d: w_valid=%b W=%h round=%0d first=%b last=%b, required 1 %h %0d %b %b",
                         t, wv, W, round, w_first, w_last, e, t, (t == 0), (t == 63));
            end
            if (noise) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL emit_in_ready t=%0d: in_ready=%b, required 0", t, in_ready);
                end
                in_valid = 1'b1;
                in_word  = $urandom;
            end
            w_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            if (wv && w_ready) begin
                cap[t] = W;
                t++;
            end
            cyc++;
        end
        if (t < stop_at) begin
            errors++;
            $display("FAIL emit_timeout: words=%0d, required %0d", t, stop_at);
        end
        if (stop_at == 64) begin
            @(negedge clk);
            w_ready  = 1'b0;
            in_valid = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || w_valid !== 1'b0) begin
                errors++;
                $display("FAIL emit_end: in_ready=%b w_valid=%b, required 1 0", in_ready, w_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; w_ready = 1'b0; in_word = '0;
        repeat (3) @(negedge clk);
        do_reset(1'b0);
    endtask

    task automatic test_abc();
        send_block(1'b0, 1'b0, 16);
        recv_block(1'b0, 1'b0, 1'b0, 64);
        checks++;
        if (cap[0] !== 32'h61626380 || cap[15] !== 32'h00000018 ||
            cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000) begin
            errors++;
            $display("FAIL abc_words: W0=%h W15=%h W16=%h W17=%h, required 61626380 00000018 61626380 000f0000",
                     cap[0], cap[15], cap[16], cap[17]);
        end
    endtask

    task automatic test_stall();
        send_block(1'b0, 1'b0, 16);
        recv_block(1'b0, 1'b1, 1'b0, 64);
    endtask

    task automatic test_load_gaps();
        send_block(1'b1, 1'b1, 16);
        recv_block(1'b1, 1'b0, 1'b0, 64);
    endtask

    task automatic test_input_noise();
        send_block(1'b1, 1'b0, 16);
        recv_block(1'b1, 1'b0, 1'b1, 64);
    endtask

    task automatic test_reset_mid();
        send_block(1'b1, 1'b0, 7);
        do_reset(1'b1);
        send_block(1'b0, 1'b0, 16);
        recv_block(1'b0, 1'b0, 1'b0, 40);
        do_reset(1'b1);
        send_block(1'b1, 1'b0, 16);
        recv_block(1'b1, 1'b0, 1'b0, 64);
    endtask

    task automatic test_back_to_back();
        int n_ir = 0, n_wv = 0, idx = 0, bcnt = 0, n_first = 0;
        int first_cyc [2];
        bit ir, wv;
        logic [31:0] e;
        first_cyc[0] = -1; first_cyc[1] = -1;
        do_reset(1'b0);
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            ir = in_ready;
            wv = w_valid;
            if (ir) n_ir++;
            if (wv) begin
                n_wv++;
                if (w_first && n_first < 2) begin
                    first_cyc[n_first] = c;
                    n_first++;
                end
                e = (idx < 64) ? exp_a[idx % 64] : exp_b[idx % 64];
                checks++;
                if (W !== e) begin
                    errors++;
                    $display("FAIL b2b_word idx=%0d: W=%h, required %h", idx, W, e);
                end
                idx++;
            end
            in_valid = (bcnt < 32);
            in_word  = (bcnt < 16) ? msg_a[bcnt] : (bcnt < 32) ? msg_b[bcnt - 16] : 32'h0;
            w_ready  = 1'b1;
            @(posedge clk);
            if (ir && in_valid) bcnt++;
        end
        in_valid = 1'b0;
        w_ready  = 1'b0;
        checks++;
        if (n_ir != 32 || n_wv != 128 || first_cyc[0] != 16 || first_cyc[1] != 96) begin
            errors++;
            $display("FAIL b2b_period: in_ready_cycles=%0d w_valid_cycles=%0d first_at=%0d,%0d, required 32 128 16,96",
                     n_ir, n_wv, first_cyc[0], first_cyc[1]);
        end
    endtask

    initial begin
        msg_a[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) msg_a[i] = 32'h0;
        msg_a[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) msg_b[i] = 32'h9e3779b9 * 32'(i + 1) ^ 32'h0badf00d;
        build_model(1'b0);
        build_model(1'b1);

        test_reset();
        test_abc();
        test_stall();
        test_load_gaps();
        test_input_noise();
        test_reset_mid();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
